// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS sequencer (master) and its datapath (slave).
// MULTICYCLE_PERF_EN adds the cycle_count / instr_retired counter outputs.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
`ifdef MULTICYCLE_PERF_EN
  , parameter int CNT_W    = 32
`endif
);
    logic                en;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                PCWrite;
    logic                PCWriteCond;
    logic [1:0]          PCSource;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                illegal;
    logic [STATE_W-1:0]  state;
`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0]    cycle_count;
    logic [CNT_W-1:0]    instr_retired;
`endif

    modport master (
        input  en, opcode, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal, state
`ifdef MULTICYCLE_PERF_EN
             , cycle_count, instr_retired
`endif
    );

    modport slave (
        output en, opcode, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal, state
`ifdef MULTICYCLE_PERF_EN
             , cycle_count, instr_retired
`endif
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/write-back with memory ready stalls.
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
`ifdef MULTICYCLE_PERF_EN
  , parameter int CNT_W    = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_R_WB      = 4'd8,
        S_EXEC_I    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    // Moore control word for a state; fetch marks the state whose IR/PC loads wait on mem_ready.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = {$bits(ctrl_t){1'b0}};
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:    c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            S_I_WB:      c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default:     c = {$bits(ctrl_t){1'b0}};
        endcase
        return c;
    endfunction

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   boundary_next_s;

    // Next state; en is only consulted in IDLE and when an instruction retires.
    always_comb begin
        state_d         = state_q;
        boundary_next_s = 1'b0;
        case (state_q)
            S_IDLE:      state_d = bus.en ? S_FETCH : S_IDLE;
            S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_RTYPE:                 state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    boundary_next_s = 1'b1;
                    state_d         = bus.en ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_EXEC_R:    state_d = S_R_WB;
            S_EXEC_I:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                boundary_next_s = 1'b1;
                state_d         = bus.en ? S_FETCH : S_IDLE;
            end
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase
    end

    // State, registered control word and sticky illegal flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= {$bits(ctrl_t){1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= decode_ctrl(state_d);
            illegal_q <= illegal_q | (state_d == S_TRAP);
        end
    end

    // IR load and PC increment are gated by mem_ready so a stalled fetch bumps the PC once.
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.IRWrite     = ctrl_q.fetch & bus.mem_ready;
    assign bus.PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready);
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.illegal     = illegal_q;
    assign bus.state       = STATE_W'(state_q);

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] instr_retired_q;

    // Free-running performance counters; both wrap silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count_q   <= {CNT_W{1'b0}};
            instr_retired_q <= {CNT_W{1'b0}};
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_TRAP)) begin
                cycle_count_q <= cycle_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cycle_count_q <= cycle_count_q;
            end
            if (boundary_next_s) begin
                instr_retired_q <= instr_retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                instr_retired_q <= instr_retired_q;
            end
        end
    end

    assign bus.cycle_count   = cycle_count_q;
    assign bus.instr_retired = instr_retired_q;
`else
    logic unused_boundary_s;
    assign unused_boundary_s = boundary_next_s;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/control word/illegal flag.
// Counter checks are compiled in when MULTICYCLE_PERF_EN is defined.
module tb_multicycle_control;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3,
                           MEM_READ = 4'd4, MEM_WB = 4'd5, MEM_WRITE = 4'd6, EXEC_R = 4'd7,
                           R_WB = 4'd8, EXEC_I = 4'd9, I_WB = 4'd10, BRANCH = 4'd11,
                           JUMP = 4'd12, TRAP = 4'd13;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ANDI = 6'b001100,
                           OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       en;
        logic       rdy;
        logic [5:0] op;
        logic       ill;
    } step_t;

    step_t sb[$];

    logic [15:0] obs_ctrl_s;
    assign obs_ctrl_s = {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                         bus.PCWriteCond, bus.PCSource, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                         bus.RegDst, bus.MemtoReg, bus.RegWrite};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Control word each state must present, written straight from the state table.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic iord, mr, mw, irw, pcw, pcc, asa, rd, m2r, rw;
        logic [1:0] pcs, asb, aop;
        {iord, mr, mw, irw, pcw, pcc, asa, rd, m2r, rw} = 10'b0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            FETCH:     begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            DECODE:    asb = 2'b11;
            MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; end
            MEM_READ:  begin iord = 1'b1; mr = 1'b1; end
            MEM_WB:    begin m2r = 1'b1; rw = 1'b1; end
            MEM_WRITE: begin iord = 1'b1; mw = 1'b1; end
            EXEC_R:    begin asa = 1'b1; aop = 2'b10; end
            R_WB:      begin rd = 1'b1; rw = 1'b1; end
            EXEC_I:    begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
            I_WB:      rw = 1'b1;
            BRANCH:    begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; end
            JUMP:      begin pcw = 1'b1; pcs = 2'b10; end
            default:   ;
        endcase
        return {iord, mr, mw, irw, pcw, pcc, pcs, asa, asb, aop, rd, m2r, rw};
    endfunction

    task automatic add(input logic [3:0] st, input logic e, input logic r,
                       input logic [5:0] o, input logic il);
        step_t s;
        s.st = st; s.en = e; s.rdy = r; s.op = o; s.ill = il;
        sb.push_back(s);
    endtask

    // Drive each queued cycle's inputs, then pop and compare mid-cycle.
    task automatic run_queue();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            bus.en = s.en; bus.mem_ready = s.rdy; bus.opcode = s.op;
            @(negedge clk);
            check_eq("state", 32'(bus.state), 32'(s.st));
            check_eq("ctrl", 32'(obs_ctrl_s), 32'(exp_ctrl(s.st, s.rdy)));
            check_eq("illegal", 32'(bus.illegal), 32'(s.ill));
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b0; bus.en = 1'b0; bus.mem_ready = 1'b0; bus.opcode = OP_R;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_state", 32'(bus.state), 32'(IDLE));
        check_eq("reset_ctrl", 32'(obs_ctrl_s), 32'd0);
        check_eq("reset_illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // lw (rdy low in non-memory states is ignored), then sw with 3 stall cycles
        add(IDLE, 1'b1, 1'b0, OP_LW, 1'b0);   add(FETCH, 1'b1, 1'b1, OP_LW, 1'b0);
        add(DECODE, 1'b1, 1'b0, OP_LW, 1'b0); add(MEM_ADDR, 1'b1, 1'b0, OP_LW, 1'b0);
        add(MEM_READ, 1'b1, 1'b1, OP_LW, 1'b0); add(MEM_WB, 1'b1, 1'b0, OP_LW, 1'b0);
        add(FETCH, 1'b1, 1'b1, OP_SW, 1'b0);  add(DECODE, 1'b1, 1'b1, OP_SW, 1'b0);
        add(MEM_ADDR, 1'b1, 1'b1, OP_SW, 1'b0);
        for (int i = 0; i < 3; i++) add(MEM_WRITE, 1'b1, 1'b0, OP_SW, 1'b0);
        add(MEM_WRITE, 1'b1, 1'b1, OP_SW, 1'b0);
        // beq, j, andi
        add(FETCH, 1'b1, 1'b1, OP_BEQ, 1'b0); add(DECODE, 1'b1, 1'b1, OP_BEQ, 1'b0);
        add(BRANCH, 1'b1, 1'b0, OP_BEQ, 1'b0);
        add(FETCH, 1'b1, 1'b1, OP_J, 1'b0);   add(DECODE, 1'b1, 1'b1, OP_J, 1'b0);
        add(JUMP, 1'b1, 1'b1, OP_J, 1'b0);
        add(FETCH, 1'b1, 1'b1, OP_ANDI, 1'b0); add(DECODE, 1'b1, 1'b1, OP_ANDI, 1'b0);
        add(EXEC_I, 1'b1, 1'b0, OP_ANDI, 1'b0); add(I_WB, 1'b1, 1'b1, OP_ANDI, 1'b0);
        // lw with a stalled fetch and a stalled read
        add(FETCH, 1'b1, 1'b0, OP_LW, 1'b0);  add(FETCH, 1'b1, 1'b1, OP_LW, 1'b0);
        add(DECODE, 1'b1, 1'b1, OP_LW, 1'b0); add(MEM_ADDR, 1'b1, 1'b1, OP_LW, 1'b0);
        add(MEM_READ, 1'b1, 1'b0, OP_LW, 1'b0); add(MEM_READ, 1'b1, 1'b0, OP_LW, 1'b0);
        add(MEM_READ, 1'b1, 1'b1, OP_LW, 1'b0); add(MEM_WB, 1'b1, 1'b1, OP_LW, 1'b0);
        // R-type with en dropped mid-instruction: completes, then idles
        add(FETCH, 1'b1, 1'b1, OP_R, 1'b0);   add(DECODE, 1'b1, 1'b1, OP_R, 1'b0);
        add(EXEC_R, 1'b0, 1'b1, OP_R, 1'b0);  add(R_WB, 1'b0, 1'b1, OP_R, 1'b0);
        add(IDLE, 1'b0, 1'b1, OP_R, 1'b0);    add(IDLE, 1'b1, 1'b1, OP_BAD, 1'b0);
        // illegal opcode: sticky trap
        add(FETCH, 1'b1, 1'b0, OP_BAD, 1'b0); add(FETCH, 1'b1, 1'b1, OP_BAD, 1'b0);
        add(DECODE, 1'b1, 1'b1, OP_BAD, 1'b0); add(TRAP, 1'b1, 1'b1, OP_BAD, 1'b1);
        add(TRAP, 1'b0, 1'b1, OP_LW, 1'b1);   add(TRAP, 1'b1, 1'b0, OP_R, 1'b1);
        run_queue();

        // asynchronous reset mid-cycle clears TRAP and illegal immediately
        #2 rst = 1'b0;
        #1;
        check_eq("trap_rst_state", 32'(bus.state), 32'(IDLE));
        check_eq("trap_rst_illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // reset during a stalled store: MemWrite drops at once and stays low
        add(IDLE, 1'b1, 1'b1, OP_SW, 1'b0);   add(FETCH, 1'b1, 1'b1, OP_SW, 1'b0);
        add(DECODE, 1'b1, 1'b1, OP_SW, 1'b0); add(MEM_ADDR, 1'b1, 1'b1, OP_SW, 1'b0);
        add(MEM_WRITE, 1'b1, 1'b0, OP_SW, 1'b0);
        run_queue();
        #2 rst = 1'b0;
        #1;
        check_eq("abort_state", 32'(bus.state), 32'(IDLE));
        check_eq("abort_memwrite", 32'(bus.MemWrite), 32'd0);
        @(posedge clk); #1;
        check_eq("abort_held_ctrl", 32'(obs_ctrl_s), 32'(exp_ctrl(IDLE, bus.mem_ready)));
        rst = 1'b1;

`ifdef MULTICYCLE_PERF_EN
        check_eq("perf_reset_cycles", bus.cycle_count, 32'd0);
        add(IDLE, 1'b1, 1'b1, OP_LW, 1'b0);   add(FETCH, 1'b1, 1'b1, OP_LW, 1'b0);
        add(DECODE, 1'b1, 1'b1, OP_LW, 1'b0); add(MEM_ADDR, 1'b1, 1'b1, OP_LW, 1'b0);
        add(MEM_READ, 1'b1, 1'b1, OP_LW, 1'b0); add(MEM_WB, 1'b1, 1'b1, OP_LW, 1'b0);
        add(FETCH, 1'b1, 1'b1, OP_BEQ, 1'b0); add(DECODE, 1'b1, 1'b1, OP_BEQ, 1'b0);
        add(BRANCH, 1'b1, 1'b1, OP_BEQ, 1'b0);
        add(FETCH, 1'b1, 1'b1, OP_ADDI, 1'b0); add(DECODE, 1'b1, 1'b1, OP_ADDI, 1'b0);
        add(EXEC_I, 1'b1, 1'b1, OP_ADDI, 1'b0); add(I_WB, 1'b0, 1'b1, OP_ADDI, 1'b0);
        add(IDLE, 1'b0, 1'b1, OP_ADDI, 1'b0);
        run_queue();
        check_eq("perf_cycles", bus.cycle_count, 32'd12);
        check_eq("perf_retired", bus.instr_retired, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy control FSM that sequences a multi-cycle MIPS datapath.
- The datapath has one shared instruction/data memory, one ALU, and IR, A, B and ALUOut holding registers.
- Replaces the single-cycle Control_Unit: it decodes the opcode once per instruction and steps the datapath through fetch, decode, execute, memory and write-back over 3-5+ cycles.
- Memory accesses use a ready handshake, so the FSM stalls on slow memory.

Parameters:
- OPCODE_W, 6, opcode field width.
- STATE_W, 4, width of the exported state register.
- CNT_W, 32, width of the performance counters (only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  run enable; sampled only in IDLE and at instruction boundaries.
- opcode  input  OPCODE_W  instruction[31:26] from the IR.
- mem_ready  input  1  memory completed the current read/write this cycle.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load IR from memory read data.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load when ALU zero_flag = 1.
- PCSource  output  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- ALUOp  output  2  to ALU_CU: 00 = add, 01 = sub, 10 = funct, 11 = immediate op by opcode.
- RegDst  output  1  register write destination: 0 = rt, 1 = rd.
- MemtoReg  output  1  register write-back data: 0 = ALUOut, 1 = MDR.
- RegWrite  output  1  register file write enable.
- illegal  output  1  sticky flag: unsupported opcode was decoded.
- state  output  STATE_W  current FSM state, for debug and the bench.

Behaviour:
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6, EXEC_R = 7, R_WB = 8, EXEC_I = 9, I_WB = 10, BRANCH = 11, JUMP = 12, TRAP = 13.
- Reset (rst = 0, asynchronous):
  - state = IDLE, illegal = 0.
  - All outputs decode to 0 in IDLE.
  - Reset asserted mid-instruction aborts the instruction immediately; no partial write is issued after reset.
- Every output not listed for a state is 0.
- IDLE: go to FETCH when en = 1.
- FETCH:
  - IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = PCWrite = mem_ready (Mealy-gated), so the PC increments exactly once per fetch.
  - Stay while mem_ready = 0; go to DECODE on mem_ready = 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (computes the branch target).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
    - 000000 -> EXEC_R.
    - 001000, 001100, 001101 -> EXEC_I.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - any other opcode -> TRAP.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ:
  - IorD = 1, MemRead = 1.
  - Hold until mem_ready = 1, then go to MEM_WB.
- MEM_WB: RegDst = 0, MemtoReg = 1, RegWrite = 1 for exactly one cycle.
- MEM_WRITE:
  - IorD = 1, MemWrite = 1, held constant while waiting.
  - Leave on mem_ready = 1.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10, then go to R_WB.
- R_WB: RegDst = 1, MemtoReg = 0, RegWrite = 1.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11, then go to I_WB.
- I_WB: RegDst = 0, MemtoReg = 0, RegWrite = 1.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
- JUMP: PCWrite = 1, PCSource = 10.
- Instruction-boundary states are MEM_WB, MEM_WRITE (on mem_ready), R_WB, I_WB, BRANCH and JUMP. From each, go to FETCH if en = 1, else IDLE.
- Dropping en mid-instruction never stalls or aborts the instruction; it is honoured only at the boundary.
- TRAP: set illegal = 1 and stay in TRAP until reset; no memory or register writes occur.
- Cycle counts with mem_ready tied to 1:
  - lw = 5 cycles.
  - sw, R-type and I-type = 4 cycles.
  - beq and j = 3 cycles.
- Each cycle of mem_ready = 0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_ready is ignored in every state that issues no memory request.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- When defined, two output ports are added, both CNT_W wide and cleared by reset:
  - cycle_count: increments every cycle where state != IDLE and state != TRAP.
  - instr_retired: increments once per instruction on its boundary state transition.
- Both counters wrap modulo 2^CNT_W without flagging.
- When not defined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then en = 1, mem_ready = 1, opcode = 100011 (lw):
  - states visited IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH.
  - RegWrite = 1 and MemtoReg = 1 only in MEM_WB.
  - PCWrite pulses once.
- opcode = 101011 (sw) with mem_ready low for 3 cycles in MEM_WRITE:
  - MemWrite = 1 and IorD = 1 held stable for 4 cycles.
  - RegWrite never asserted.
  - returns to FETCH.
- opcode = 000100 (beq):
  - 3 cycles total.
  - in BRANCH, PCWriteCond = 1, PCSource = 01, ALUOp = 01.
  - next state FETCH.
- opcode = 001100 (andi) then 000000 (R-type):
  - I_WB has RegDst = 0, ALUOp was 11 in EXEC_I.
  - R_WB has RegDst = 1, ALUOp was 10 in EXEC_R.
- opcode = 111111:
  - goes to TRAP after DECODE, illegal = 1 and sticky.
  - rst = 0 mid-TRAP clears illegal and state asynchronously.
  - en = 0 during EXEC_R completes R_WB, then goes to IDLE.
- With MULTICYCLE_PERF_EN defined, run lw + beq + addi at mem_ready = 1: instr_retired = 3, cycle_count = 12.
